// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Operands are registered for the EXEC cycle; the result comes back in RESP tagged with the owner.
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             Req0_Valid,
  output logic             Req0_Ready,
  input  logic [WIDTH-1:0] Req0_A,
  input  logic [WIDTH-1:0] Req0_Reg_Data,
  input  logic [WIDTH-1:0] Req0_Ext_Imm,
  input  logic             Req0_ALU_Src,
  input  logic [OP_W-1:0]  Req0_Op,

  input  logic             Req1_Valid,
  output logic             Req1_Ready,
  input  logic [WIDTH-1:0] Req1_A,
  input  logic [WIDTH-1:0] Req1_Reg_Data,
  input  logic [WIDTH-1:0] Req1_Ext_Imm,
  input  logic             Req1_ALU_Src,
  input  logic [OP_W-1:0]  Req1_Op,

  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_Reg_Data,
  output logic [WIDTH-1:0] ALU_Ext_Imm,
  output logic             ALU_Src,
  output logic [OP_W-1:0]  ALU_Op,
  input  logic [WIDTH-1:0] ALU_Result,
  input  logic             ALU_Zero,

  output logic             Resp_Valid,
  output logic             Resp_ID,
  output logic [WIDTH-1:0] Resp_Result,
  output logic             Resp_Zero,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               owner_q, owner_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_reg_q, alu_reg_d;
  logic [WIDTH-1:0]   alu_ext_q, alu_ext_d;
  logic               alu_src_q, alu_src_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic [WIDTH-1:0]   resp_result_q, resp_result_d;
  logic               resp_zero_q, resp_zero_d;
  logic               resp_id_q, resp_id_d;

  logic               grant;
  logic               accept;

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    grant = 1'b0;
    if (Req0_Valid && Req1_Valid) begin
      grant = ~last_grant_q;
    end else if (Req1_Valid) begin
      grant = 1'b1;
    end
  end

  assign accept     = (state_q == IDLE) && (Req0_Valid || Req1_Valid) && !reset;
  assign Req0_Ready = accept && !grant;
  assign Req1_Ready = accept && grant;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    alu_a_d       = alu_a_q;
    alu_reg_d     = alu_reg_q;
    alu_ext_d     = alu_ext_q;
    alu_src_d     = alu_src_q;
    alu_op_d      = alu_op_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp_id_d     = resp_id_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = EXEC;
          last_grant_d = grant;
          owner_d      = grant;
          alu_a_d      = grant ? Req1_A        : Req0_A;
          alu_reg_d    = grant ? Req1_Reg_Data : Req0_Reg_Data;
          alu_ext_d    = grant ? Req1_Ext_Imm  : Req0_Ext_Imm;
          alu_src_d    = grant ? Req1_ALU_Src  : Req0_ALU_Src;
          alu_op_d     = grant ? Req1_Op       : Req0_Op;
        end
      end
      EXEC: begin
        state_d       = RESP;
        resp_result_d = ALU_Result;
        resp_zero_d   = ALU_Zero;
        resp_id_d     = owner_q;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      alu_a_q       <= '0;
      alu_reg_q     <= '0;
      alu_ext_q     <= '0;
      alu_src_q     <= 1'b0;
      alu_op_q      <= '0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_id_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      alu_a_q       <= alu_a_d;
      alu_reg_q     <= alu_reg_d;
      alu_ext_q     <= alu_ext_d;
      alu_src_q     <= alu_src_d;
      alu_op_q      <= alu_op_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp_id_q     <= resp_id_d;
    end
  end

  assign ALU_A        = alu_a_q;
  assign ALU_Reg_Data = alu_reg_q;
  assign ALU_Ext_Imm  = alu_ext_q;
  assign ALU_Src      = alu_src_q;
  assign ALU_Op       = alu_op_q;
  assign Resp_Valid   = (state_q == RESP);
  assign Resp_ID      = resp_id_q;
  assign Resp_Result  = resp_result_q;
  assign Resp_Zero    = resp_zero_q;
  assign Busy         = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single ALU and its operand mux (register vs. extended-immediate select) between two requesters.
- Requester 0 is the main datapath. Requester 1 is an auxiliary unit, for example address generation or debug.
- Arbitrates round-robin and registers the winning operands onto the shared ALU inputs for one full cycle.
- Captures the ALU result and returns it with a requester ID.

Parameters:
- WIDTH, 16, datapath width of operands and result.
- OP_W, 3, width of the ALU operation code.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Req0_Valid  input  1  requester 0 has an operation pending.
- Req0_Ready  output  1  requester 0 operation accepted this cycle.
- Req0_A  input  WIDTH  operand A.
- Req0_Reg_Data  input  WIDTH  register operand B.
- Req0_Ext_Imm  input  WIDTH  extended-immediate operand B.
- Req0_ALU_Src  input  1  0 = select Reg_Data, 1 = select Ext_Imm.
- Req0_Op  input  OP_W  ALU operation.
- Req1_Valid, Req1_Ready, Req1_A, Req1_Reg_Data, Req1_Ext_Imm, Req1_ALU_Src, Req1_Op: same as Req0_* for requester 1.
- ALU_A  output  WIDTH  to ALU operand A.
- ALU_Reg_Data  output  WIDTH  to operand mux, register input.
- ALU_Ext_Imm  output  WIDTH  to operand mux, immediate input.
- ALU_Src  output  1  to operand mux select.
- ALU_Op  output  OP_W  to ALU control.
- ALU_Result  input  WIDTH  combinational ALU output.
- ALU_Zero  input  1  combinational ALU zero flag.
- Resp_Valid  output  1  one-cycle pulse; response fields valid.
- Resp_ID  output  1  requester that owns the response.
- Resp_Result  output  WIDTH  captured ALU result.
- Resp_Zero  output  1  captured zero flag.
- Busy  output  1  high whenever the state is not IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
  - IDLE -> EXEC on acceptance.
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
  - Throughput: one operation per 3 cycles.
- Acceptance happens only in IDLE.
  - Ready is combinational: ReqN_Ready = (state == IDLE) & ReqN_Valid & (grant == N).
  - At most one Ready is high in any cycle.
  - Ready is never high in EXEC or RESP.
- Arbitration:
  - Only one Valid: grant that requester.
  - Both Valid: grant the requester not in Last_Grant.
  - Last_Grant updates on every acceptance.
  - Reset value of Last_Grant is 1, so requester 0 wins the first tie.
- Operand registers:
  - On the acceptance edge, ALU_A, ALU_Reg_Data, ALU_Ext_Imm, ALU_Src and ALU_Op load from the granted requester; the owner ID is stored.
  - These outputs are stable throughout EXEC, independent of request-input changes.
  - They hold their values after EXEC until the next acceptance.
- Capture: on the EXEC->RESP edge, Resp_Result <= ALU_Result, Resp_Zero <= ALU_Zero and Resp_ID <= owner.
- Resp_Valid:
  - High exactly during the RESP cycle.
  - Resp_Result, Resp_Zero and Resp_ID hold until the next capture.
- Latency: request accepted in cycle N (Ready high) -> ALU inputs driven in N+1 -> Resp_Valid in N+2.
- No arithmetic is performed here; widths pass through unchanged.
- Valid dropped before Ready: no effect, no state change. Valid held after Ready: treated as a new request at the next IDLE.
- Reset (synchronous, any state, including mid-operation):
  - state IDLE, Busy 0, Resp_Valid 0.
  - All ALU_* and Resp_* outputs 0; Last_Grant 1.
  - An in-flight operation is discarded with no response.
  - Ready is 0 while reset is high.

Test Plan:
- Post-reset, only Req0 valid: A=0x0003, Reg_Data=0x1234, Ext_Imm=0x5678, ALU_Src=1, Op=ADD; bench ALU model returns A+B. Required response:
  - Req0_Ready high in cycle N.
  - In N+1: ALU_Src=1, ALU_Ext_Imm=0x5678, ALU_A=0x0003.
  - In N+2: Resp_Valid=1, Resp_ID=0, Resp_Result=0x567B, exactly one cycle long.
- Same request with ALU_Src=0: ALU_Reg_Data=0x1234 is selected, Resp_Result=0x1237.
- Both Valid held continuously for 4 operations: grants go 0,1,0,1; Ready pulses are 3 cycles apart; Resp_IDs match the grants.
- Only Req1 valid, 3 back-to-back operations: all granted to 1, Resp_ID=1 each time, no idle cycles beyond the 3-cycle cadence.
- Request inputs changed to 0xFFFF during EXEC: ALU_* outputs stay at the accepted values; Ready stays low during EXEC and RESP.
- Reset pulsed in EXEC: no Resp_Valid follows; Busy=0 and all outputs 0 the next cycle; a subsequent tie is granted to Req0.
- ALU_Result=0x0000 with ALU_Zero=1: Resp_Zero=1, Resp_Result=0x0000.
